matrix_ram: RTL and testbench

- Parametrised matrix row store for the matrix engine: DEPTH rows, each ELEMS elements of ELEM_W bits.
- Adds over the fixed 256x16 store:
  - valid/ready request handshake
  - per-element write mask
  - registered read-valid strobe
  - multi-cycle bulk-clear sequencer
  - asynchronous active-low reset of control state
- Sits between the top-level controller and the ALU/matrix units on the shared row data bus.

---
 rtl/matrix_ram.sv | 119 +++++++++++
 tb/tb_matrix_ram.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ram.sv
// rtl/matrix_ram.sv - parametrised matrix row store with masked writes and bulk clear
//
// Row store for the matrix engine: DEPTH rows of ELEMS elements, ELEM_W bits each.
// Optional macro MATRIX_RAM_HIZ_EN: drive DataOut to high-z outside the DataValid cycle.
//
// Ports:
//   Clock      rising-edge clock
//   nReset     asynchronous active-low reset of control state (array is not reset)
//   Enable     request valid
//   ReadWrite  1 = read, 0 = write
//   Clear      start bulk clear of all rows
//   Address    row address
//   DataIn     write data, element i = DataIn[i*ELEM_W +: ELEM_W]
//   ElemMask   per-element write enable
//   DataOut    read data
//   DataValid  one-cycle strobe marking new read data
//   Ready      request or Clear can be accepted this cycle

module matrix_ram #(
   parameter int ELEM_W = 16,
   parameter int ELEMS  = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                    Clock,
   input  logic                    nReset,
   input  logic                    Enable,
   input  logic                    ReadWrite,
   input  logic                    Clear,
   input  logic [ADDR_W-1:0]       Address,
   input  logic [ELEM_W*ELEMS-1:0] DataIn,
   input  logic [ELEMS-1:0]        ElemMask,
   output logic [ELEM_W*ELEMS-1:0] DataOut,
   output logic                    DataValid,
   output logic                    Ready
);

   localparam int ROW_W = ELEM_W * ELEMS;
   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ROW_W-1:0]  rd_data_q;
   logic              valid_q;

   logic [ROW_W-1:0]  mem [DEPTH];

   logic in_range;
   logic do_write;

   assign in_range = ({1'b0, Address} < DEPTH_V);

   // Ready also drops while nReset is asserted so nothing is written into the
   // array during reset.
   assign Ready    = nReset && (state == IDLE) && !Clear;
   assign do_write = Enable && Ready && !ReadWrite && in_range;

   // Array has no reset; contents survive nReset. During CLEAR the sequencer
   // owns the write port, otherwise the masked request write does.
   always_ff @(posedge Clock) begin
      if (state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (do_write) begin
         for (int i = 0; i < ELEMS; i++) begin
            if (ElemMask[i]) begin
               mem[Address][i*ELEM_W +: ELEM_W] <= DataIn[i*ELEM_W +: ELEM_W];
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         clr_cnt   <= '0;
         rd_data_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               // Clear has priority over any request in the same cycle.
               if (Clear) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end else if (Enable && ReadWrite) begin
                  rd_data_q <= in_range ? mem[Address] : '0;
                  valid_q   <= 1'b1;
               end
            end
            CLEAR: begin
               // Clear held high here is ignored; it is seen again in IDLE.
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_ROW) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign DataValid = valid_q;

`ifdef MATRIX_RAM_HIZ_EN
   // Legacy shared tri-state bus: release the bus outside the valid cycle.
   assign DataOut = valid_q ? rd_data_q : {ROW_W{1'bz}};
`else
   assign DataOut = rd_data_q;
`endif

endmodule

// File: tb/tb_matrix_ram.sv
// tb/tb_matrix_ram.sv - directed self-checking bench for matrix_ram

module tb_matrix_ram;

   logic         Clock = 1'b0;
   logic         nReset;
   logic         en, rw, clr;
   logic [3:0]   addr;
   logic [255:0] din;
   logic [15:0]  mask;
   logic [255:0] dout;
   logic         dv, rdy;

   logic         en12, rw12, clr12;
   logic [3:0]   addr12;
   logic [255:0] din12;
   logic [15:0]  mask12;
   logic [255:0] dout12;
   logic         dv12, rdy12;

   int checks   = 0;
   int failures = 0;

`ifdef MATRIX_RAM_HIZ_EN
   localparam logic [255:0] IDLE_OUT = {256{1'bz}};
`else
   localparam logic [255:0] IDLE_OUT = '0;
`endif

   localparam logic [255:0] R3 =
      256'h0004_000c_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_0003;
   localparam logic [255:0] MASK_EXP =
      256'h1111_1111_1111_1111_1111_1111_1111_1111_abcd_abcd_abcd_abcd_1111_1111_1111_1111;

   always #5 Clock = ~Clock;

   matrix_ram #(.ELEM_W(16), .ELEMS(16), .DEPTH(16), .ADDR_W(4)) u_dut (
      .Clock(Clock), .nReset(nReset), .Enable(en), .ReadWrite(rw), .Clear(clr),
      .Address(addr), .DataIn(din), .ElemMask(mask),
      .DataOut(dout), .DataValid(dv), .Ready(rdy)
   );

   matrix_ram #(.ELEM_W(16), .ELEMS(16), .DEPTH(12), .ADDR_W(4)) u_dut12 (
      .Clock(Clock), .nReset(nReset), .Enable(en12), .ReadWrite(rw12), .Clear(clr12),
      .Address(addr12), .DataIn(din12), .ElemMask(mask12),
      .DataOut(dout12), .DataValid(dv12), .Ready(rdy12)
   );

   // Stimulus helpers: called at a falling edge, return at a falling edge.
   task automatic wr(input logic [3:0] a, input logic [255:0] d, input logic [15:0] m);
      en = 1'b1; rw = 1'b0; addr = a; din = d; mask = m;
      @(negedge Clock);
      en = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [255:0] q, output logic v1, output logic v2);
      en = 1'b1; rw = 1'b1; addr = a;
      @(negedge Clock);
      q = dout; v1 = dv; en = 1'b0;
      @(negedge Clock);
      v2 = dv;
   endtask

   task automatic wr12(input logic [3:0] a, input logic [255:0] d);
      en12 = 1'b1; rw12 = 1'b0; addr12 = a; din12 = d; mask12 = 16'hffff;
      @(negedge Clock);
      en12 = 1'b0;
   endtask

   task automatic rd12(input logic [3:0] a, output logic [255:0] q, output logic v1, output logic [255:0] q2);
      en12 = 1'b1; rw12 = 1'b1; addr12 = a;
      @(negedge Clock);
      q = dout12; v1 = dv12; en12 = 1'b0;
      @(negedge Clock);
      q2 = dout12;
   endtask

   task automatic fill_ones();
      for (int r = 0; r < 16; r++) wr(4'(r), {256{1'b1}}, 16'hffff);
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      repeat (2) @(negedge Clock);
      checks++;
      if (dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", dv); end
      checks++;
      if (dout !== IDLE_OUT) begin failures++; $display("FAIL reset_dout got=%h exp=%h", dout, IDLE_OUT); end
      nReset = 1'b1;
      #1;
      checks++;
      if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy); end
      @(negedge Clock);
      // reset arriving while the read strobe is up cancels it
      en = 1'b1; rw = 1'b1; addr = 4'd0;
      @(posedge Clock);
      #1;
      en = 1'b0;
      nReset = 1'b0;
      #1;
      checks++;
      if (dv !== 1'b0) begin failures++; $display("FAIL reset_mid_read_dv got=%b exp=0", dv); end
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_readback();
      logic [255:0] q; logic v1, v2;
      wr(4'd3, R3, 16'hffff);
      rd(4'd3, q, v1, v2);
      checks++;
      if (v1 !== 1'b1) begin failures++; $display("FAIL readback_dv got=%b exp=1", v1); end
      checks++;
      if (q !== R3) begin failures++; $display("FAIL readback_data got=%h exp=%h", q, R3); end
      checks++;
      if (v2 !== 1'b0) begin failures++; $display("FAIL readback_dv_after got=%b exp=0", v2); end
   endtask

   task automatic test_masked_write();
      logic [255:0] q; logic v1, v2;
      wr(4'd5, {16{16'h1111}}, 16'hffff);
      wr(4'd5, {16{16'habcd}}, 16'h00f0);
      rd(4'd5, q, v1, v2);
      checks++;
      if (q !== MASK_EXP || v1 !== 1'b1) begin
         failures++; $display("FAIL masked_write got=%h v=%b exp=%h", q, v1, MASK_EXP);
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] q; logic v1, v2;
      wr(4'd9, {16{16'h5a5a}}, 16'hffff);
      rd(4'd9, q, v1, v2);
      checks++;
      if (q !== {16{16'h5a5a}} || v1 !== 1'b1) begin
         failures++; $display("FAIL read_after_write got=%h v=%b exp=%h", q, v1, {16{16'h5a5a}});
      end
`ifndef MATRIX_RAM_HIZ_EN
      checks++;
      if (dout !== {16{16'h5a5a}}) begin
         failures++; $display("FAIL dout_hold got=%h exp=%h", dout, {16{16'h5a5a}});
      end
`endif
   endtask

   task automatic test_streaming();
      for (int r = 0; r < 16; r++) begin
         en = 1'b1; rw = 1'b0; addr = 4'(r); din = {16{16'(r)}}; mask = 16'hffff;
         #1;
         checks++;
         if (rdy !== 1'b1) begin failures++; $display("FAIL stream_wr_ready row=%0d got=%b exp=1", r, rdy); end
         @(negedge Clock);
      end
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            checks++;
            if (dv !== 1'b1 || dout !== {16{16'(k - 1)}}) begin
               failures++;
               $display("FAIL stream_rd row=%0d got=%h v=%b exp=%h", k - 1, dout, dv, {16{16'(k - 1)}});
            end
         end
         if (k < 16) begin
            en = 1'b1; rw = 1'b1; addr = 4'(k);
            #1;
            checks++;
            if (rdy !== 1'b1) begin failures++; $display("FAIL stream_rd_ready k=%0d got=%b exp=1", k, rdy); end
         end else begin
            en = 1'b0;
         end
         @(negedge Clock);
      end
      checks++;
      if (dv !== 1'b0) begin failures++; $display("FAIL stream_dv_end got=%b exp=0", dv); end
   endtask

   task automatic test_clear();
      logic [255:0] q; logic v1, v2;
      int n, dv_seen;
      fill_ones();
      clr = 1'b1; en = 1'b1; rw = 1'b0; addr = 4'd2; din = {16{16'h1234}}; mask = 16'hffff;
      #1;
      checks++;
      if (rdy !== 1'b0) begin failures++; $display("FAIL clear_start_ready got=%b exp=0", rdy); end
      @(negedge Clock);
      clr = 1'b0; en = 1'b0;
      n = 0; dv_seen = 0;
      while (!rdy && n < 40) begin
         if (dv !== 1'b0) dv_seen++;
         n++;
         @(negedge Clock);
      end
      checks++;
      if (n != 16) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=16", n); end
      checks++;
      if (dv_seen != 0) begin failures++; $display("FAIL clear_dv got=%0d exp=0", dv_seen); end
      for (int r = 0; r < 16; r++) begin
         rd(4'(r), q, v1, v2);
         checks++;
         if (q !== '0 || v1 !== 1'b1) begin
            failures++; $display("FAIL clear_row row=%0d got=%h v=%b exp=0", r, q, v1);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [255:0] q, e; logic v1, v2;
      fill_ones();
      clr = 1'b1;
      @(negedge Clock);
      clr = 1'b0;
      repeat (5) @(negedge Clock);
      nReset = 1'b0;
      @(negedge Clock);
      nReset = 1'b1;
      #1;
      checks++;
      if (dv !== 1'b0) begin failures++; $display("FAIL rst_clear_dv got=%b exp=0", dv); end
      checks++;
      if (rdy !== 1'b1) begin failures++; $display("FAIL rst_clear_ready got=%b exp=1", rdy); end
      for (int r = 0; r < 16; r++) begin
         e = (r < 5) ? '0 : {256{1'b1}};
         rd(4'(r), q, v1, v2);
         checks++;
         if (q !== e) begin failures++; $display("FAIL rst_clear_row row=%0d got=%h exp=%h", r, q, e); end
      end
   endtask

   task automatic test_out_of_range();
      logic [255:0] q, q2; logic v1;
      for (int r = 0; r < 12; r++) wr12(4'(r), {16{16'(16'h0100 + r)}});
      wr12(4'd13, {256{1'b1}});
      rd12(4'd13, q, v1, q2);
      checks++;
      if (q !== '0) begin failures++; $display("FAIL oor_data got=%h exp=0", q); end
      checks++;
      if (v1 !== 1'b1) begin failures++; $display("FAIL oor_dv got=%b exp=1", v1); end
`ifdef MATRIX_RAM_HIZ_EN
      checks++;
      if (q2 !== {256{1'bz}}) begin failures++; $display("FAIL oor_hiz got=%h exp=z", q2); end
`endif
      for (int r = 0; r < 12; r++) begin
         rd12(4'(r), q, v1, q2);
         checks++;
         if (q !== {16{16'(16'h0100 + r)}}) begin
            failures++; $display("FAIL oor_row row=%0d got=%h exp=%h", r, q, {16{16'(16'h0100 + r)}});
         end
      end
   endtask

   initial begin
      nReset = 1'b0; en = 1'b0; rw = 1'b0; clr = 1'b0; addr = '0; din = '0; mask = '0;
      en12 = 1'b0; rw12 = 1'b0; clr12 = 1'b0; addr12 = '0; din12 = '0; mask12 = '0;
      @(negedge Clock);
      test_reset();
      test_readback();
      test_masked_write();
      test_back_to_back();
      test_streaming();
      test_clear();
      test_reset_mid_clear();
      test_out_of_range();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
